// File: rtl/pwl_clk_sampler.sv
// Clocked consumer of a pwl net: samples at each enabled posedge and reduces
// windows of DECIM samples to mean/min/max/timestamp behind a valid/ready register.
package pwl_pkg;
  timeunit 1ns;
  timeprecision 1ps;

  typedef struct {
    real a;
    real b;
    real t0;
  } pwl;

  // Seconds per simulation time unit of the pwl modules (matches timeunit above).
  function automatic real get_timeunit();
    return 1.0e-9;
  endfunction

  function automatic real pwl_eval(pwl p, real t);
    return p.a + p.b * (t - p.t0);
  endfunction
endpackage

module pwl_clk_sampler
  import pwl_pkg::*;
#(
  parameter real scale = 1.0,
  parameter int  DECIM = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  pwl   in,
  input  logic out_ready,
  output real  out_avg,
  output real  out_min,
  output real  out_max,
  output real  out_t,
  output logic out_valid,
  output logic ovf
);
  timeunit 1ns;
  timeprecision 1ps;

  localparam real TU = get_timeunit();
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [CW-1:0] LAST = CW'(DECIM - 1);

  typedef enum logic {IDLE, ACCUM} acc_state_t;

  acc_state_t    state, state_nxt;
  logic [CW-1:0] cnt;
  real           sum, mn, mx;
  logic          take_first, complete, transfer;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    take_first = 1'b0;
    complete   = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          take_first = 1'b1;
          // DECIM=1: the first sample is also the last one
          if (cnt == LAST) complete = 1'b1;
          else             state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        if (en && cnt == LAST) begin
          complete  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign transfer = out_valid && out_ready;

  // Evaluated at the edge itself, so the segment seen is the one current there.
  function automatic real sample_now();
    return scale * pwl_eval(in, $realtime * TU);
  endfunction

  function automatic real win_sum(real v);
    return take_first ? v : sum + v;
  endfunction

  function automatic real win_min(real v);
    return (take_first || v < mn) ? v : mn;
  endfunction

  function automatic real win_max(real v);
    return (take_first || v > mx) ? v : mx;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      sum       <= 0.0;
      mn        <= 0.0;
      mx        <= 0.0;
      out_avg   <= 0.0;
      out_min   <= 0.0;
      out_max   <= 0.0;
      out_t     <= 0.0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (en) begin
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        sum <= win_sum(sample_now());
        mn  <= win_min(sample_now());
        mx  <= win_max(sample_now());
      end
      // A new result always wins; overwriting an untaken one is flagged.
      if (complete) begin
        out_avg   <= win_sum(sample_now()) / real'(DECIM);
        out_min   <= win_min(sample_now());
        out_max   <= win_max(sample_now());
        out_t     <= $realtime * TU;
        out_valid <= 1'b1;
        if (out_valid && !out_ready) ovf <= 1'b1;
      end else if (transfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pwl_clk_sampler.md
# pwl_clk_sampler

Clocked reader for the pwl signal protocol: evaluates a `pwl` input at each rising clock edge and reduces windows of DECIM samples into average, minimum, maximum and timestamp. Results go out as real values with a valid/ready handshake. It is the discrete-time consumer at the receiving end of pwl chains (pwl delay/gain primitives) and bridges a pwl net into clocked digital/DSP models.

## Interface

Parameters:
- scale, 1.0: real factor applied to every evaluated sample.
- DECIM, 4: integer samples per window; legal range ≥ 1.

Ports:
- clk  input  1  sampling clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  sample enable, checked at each posedge.
- in  input  pwl  pwl input (`input_pwl`: fields a, b, t0).
- out_ready  input  1  downstream accepts the result.
- out_avg  output  real  window mean.
- out_min  output  real  window minimum.
- out_max  output  real  window maximum.
- out_t  output  real  time in seconds of the last sample in the window.
- out_valid  output  1  result registers hold an unconsumed result.
- ovf  output  1  sticky flag: an unconsumed result was overwritten.

## Operation

- Use `get_timeunit` for TU. Current time in seconds: t = $realtime*TU.
- Sample value at a posedge with en=1: v = scale*(in.a + in.b*(t − in.t0)). The segment used is the one current at the edge; a pwl event in the same timestep as the edge is not seen until the next edge.
- Window accumulator: cnt (integer 0..DECIM−1), sum, mn, mx (real).
  - On an accepted sample with cnt=0: sum=v, mn=v, mx=v.
  - Otherwise: sum+=v, mn=min(mn,v), mx=max(mx,v).
  - cnt increments and wraps to 0 after DECIM−1.
- Accumulator FSM:
  - IDLE (cnt=0, no partial window) → ACCUM on the first accepted sample.
  - ACCUM → IDLE on the DECIMth sample (window complete).
  - With DECIM=1, every accepted sample completes a window directly from IDLE.
- en=0: no sample taken; cnt, sum, mn and mx hold. A window may span disabled cycles.
- Window complete: out_avg=sum_final/DECIM, out_min, out_max and out_t=t are loaded on the same edge, and out_valid is set to 1.
- Output register states are EMPTY (out_valid=0) and FULL (out_valid=1). Transfer occurs at a posedge where out_valid=1 and out_ready=1.
  - Transfer only: out_valid→0; data registers keep their last values.
  - Complete only, in EMPTY: load; FULL.
  - Complete only, in FULL without transfer: overwrite with the new result; ovf←1.
  - Complete and transfer on the same edge: load the new result; out_valid stays 1; no ovf.
- Sampling never stalls on backpressure; the analog input cannot be paused.
- ovf clears only on rst.

## Timing

- Reset (rst=1 at a posedge) gives cnt=0, sum=mn=mx=0.0, out_avg=out_min=out_max=out_t=0.0, out_valid=0, ovf=0. Reset takes priority over en, window completion and transfer. A partial window is discarded.
- Latency: results are visible immediately after the posedge taking the DECIMth sample, i.e. 0 cycles after the last sample edge.
- out_ready is sampled only at posedge; there is no combinational path from out_ready to outputs.
- Max throughput: one result per DECIM enabled cycles.
- Deassertion of rst: the first sample is taken at the first posedge with rst=0 and en=1.

## Test plan

- Ramp, basic window: in a=0, b=1e6, t0=0, scale=1, DECIM=4, clk period 10 ns, first enabled edges at 10/20/30/40 ns, out_ready=1. Required after the 40 ns edge: out_avg=0.025, out_min=0.01, out_max=0.04, out_t=40e-9, out_valid=1 for exactly one cycle.
- Scale and constant input: a=0.5, b=0, scale=2.0, DECIM=1. Required: out_avg=out_min=out_max=1.0 every cycle, out_valid continuously 1.
- Segment change mid-window: a=1, b=0 for 2 samples, then a pwl event to a=−1, b=0, DECIM=4. Required: out_avg=0.0, out_min=−1.0, out_max=1.0.
- Backpressure: out_ready=0 across two window completions. Required: ovf=1 after the second completion, out regs hold the second window, out_valid=1. Then out_ready=1 for one edge: out_valid=0, ovf stays 1.
- Simultaneous complete and transfer: out_ready pulses high exactly on a completion edge while FULL. Required: new result loaded, out_valid stays 1, ovf=0.
- en gaps and reset mid-window: en toggles 1,0,1,0 over windows; the window must complete on the 4th enabled sample. Assert rst after 2 of 4 samples. Required: all outputs 0.0/0 after that edge, and the next result is built from 4 fresh post-reset samples.
